// File: rtl/read_xbar_if.sv
// Read crossbar bus bundle: agent request/return lanes and bank read ports.
// master = agents plus banks (the environment around the crossbar), slave = the crossbar.
interface read_xbar_if #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NB_BANK      = 2,
  parameter int unsigned NB_RDAGENT   = 2,
  parameter int unsigned SELECT_WIDTH = 2
);
  logic [NB_RDAGENT-1:0]              m_rden;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select;
  logic [NB_RDAGENT-1:0]              m_rdready;
  logic [NB_RDAGENT-1:0]              m_rddvalid;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]   m_rddata;
  logic [NB_RDAGENT*2-1:0]            m_rdcollision;
  logic [NB_BANK-1:0]                 s_rden;
  logic [NB_BANK*ADDR_WIDTH-1:0]      s_rdaddr;
  logic [NB_BANK*DATA_WIDTH-1:0]      s_rddata;

  modport master (
    output m_rden, m_rdaddr, bank_select, s_rddata,
    input  m_rdready, m_rddvalid, m_rddata, m_rdcollision, s_rden, s_rdaddr
  );

  modport slave (
    input  m_rden, m_rdaddr, bank_select, s_rddata,
    output m_rdready, m_rddvalid, m_rddata, m_rdcollision, s_rden, s_rdaddr
  );
endinterface

// File: rtl/read_xbar.sv
// Read crossbar: per-bank arbitration with ready stall, tagged return pipeline, collision flags.
// Define READ_XBAR_RR_EN for round-robin arbitration; otherwise highest-index requester wins.
module read_xbar #(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NB_BANK         = 2,
  parameter int unsigned NB_RDAGENT      = 2,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned WRITE_COLLISION = 1,
  parameter int unsigned SELECT_WIDTH    = ((NB_BANK > 1) ? $clog2(NB_BANK) : 1) + WRITE_COLLISION
) (
  input logic        aclk,
  input logic        aresetn,
  read_xbar_if.slave bus
);
  localparam int unsigned BIDX_W = SELECT_WIDTH - WRITE_COLLISION;
  localparam int unsigned AGW    = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;

  typedef struct packed {
    logic              vld;
    logic              oor;
    logic [BIDX_W-1:0] bidx;
    logic              wr;
    logic              rd;
  } ret_t;

  logic [NB_RDAGENT-1:0][BIDX_W-1:0] bidx;
  logic [NB_RDAGENT-1:0]             wrflag;
  logic [NB_RDAGENT-1:0]             in_range;
  logic [NB_RDAGENT-1:0]             rdcoll;
  logic [NB_RDAGENT-1:0]             grant;
  logic [NB_BANK-1:0][NB_RDAGENT-1:0] breq;
  logic [NB_BANK-1:0][AGW-1:0]       win_idx;
  logic [NB_BANK-1:0]                bact;
  logic [NB_BANK*ADDR_WIDTH-1:0]     s_addr;
  logic [NB_RDAGENT-1:0]             rvalid;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]  rdata;
  logic [NB_RDAGENT*2-1:0]           rcoll;
  ret_t                              pipe_q [NB_RDAGENT][RD_LATENCY];

`ifdef READ_XBAR_RR_EN
  logic [NB_BANK-1:0][AGW-1:0] ptr_q;

  function automatic logic [AGW-1:0] pick(input logic [NB_RDAGENT-1:0] req,
                                          input logic [AGW-1:0]        ptr);
    logic [AGW-1:0] sel;
    sel = '0;
    // Scan farthest-first so the nearest requester after ptr overwrites last.
    for (int k = NB_RDAGENT; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NB_RDAGENT]) sel = AGW'((int'(ptr) + k) % NB_RDAGENT);
    end
    return sel;
  endfunction
`else
  function automatic logic [AGW-1:0] pick(input logic [NB_RDAGENT-1:0] req);
    logic [AGW-1:0] sel;
    sel = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      if (req[i]) sel = AGW'(i);
    end
    return sel;
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < NB_RDAGENT; i++) begin
      bidx[i]     = bus.bank_select[i*SELECT_WIDTH +: BIDX_W];
      wrflag[i]   = (WRITE_COLLISION != 0) && bus.bank_select[i*SELECT_WIDTH + SELECT_WIDTH - 1];
      in_range[i] = 32'(bidx[i]) < NB_BANK;
    end
  end

  always_comb begin
    breq    = '0;
    win_idx = '0;
    bact    = '0;
    s_addr  = '0;
    for (int b = 0; b < NB_BANK; b++) begin
      for (int i = 0; i < NB_RDAGENT; i++) begin
        breq[b][i] = aresetn && bus.m_rden[i] && in_range[i] && (32'(bidx[i]) == 32'(b));
      end
      bact[b] = |breq[b];
`ifdef READ_XBAR_RR_EN
      win_idx[b] = pick(breq[b], ptr_q[b]);
`else
      win_idx[b] = pick(breq[b]);
`endif
      if (bact[b]) begin
        s_addr[b*ADDR_WIDTH +: ADDR_WIDTH] =
            bus.m_rdaddr[32'(win_idx[b])*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Out-of-range selects are granted at once and never touch a bank.
  always_comb begin
    for (int i = 0; i < NB_RDAGENT; i++) begin
      grant[i]  = aresetn && bus.m_rden[i] && !in_range[i];
      rdcoll[i] = 1'b0;
      for (int b = 0; b < NB_BANK; b++) begin
        if (breq[b][i]) begin
          grant[i]  = (32'(win_idx[b]) == 32'(i));
          rdcoll[i] = $countones(breq[b]) > 1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NB_RDAGENT; i++) begin
        for (int s = 0; s < RD_LATENCY; s++) pipe_q[i][s] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_RDAGENT; i++) begin
        pipe_q[i][0] <= '{vld: grant[i], oor: !in_range[i], bidx: bidx[i],
                          wr: wrflag[i], rd: rdcoll[i]};
        for (int s = 1; s < RD_LATENCY; s++) pipe_q[i][s] <= pipe_q[i][s-1];
      end
    end
  end

`ifdef READ_XBAR_RR_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int b = 0; b < NB_BANK; b++) ptr_q[b] <= AGW'(NB_RDAGENT - 1);
    end else begin
      for (int b = 0; b < NB_BANK; b++) begin
        if (bact[b]) ptr_q[b] <= win_idx[b];
      end
    end
  end
`endif

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    rcoll  = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      if (pipe_q[i][RD_LATENCY-1].vld) begin
        rvalid[i]       = 1'b1;
        rcoll[2*i +: 2] = {pipe_q[i][RD_LATENCY-1].rd, pipe_q[i][RD_LATENCY-1].wr};
        if (!pipe_q[i][RD_LATENCY-1].oor) begin
          rdata[i*DATA_WIDTH +: DATA_WIDTH] =
              bus.s_rddata[32'(pipe_q[i][RD_LATENCY-1].bidx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign bus.m_rdready     = grant;
  assign bus.s_rden        = bact;
  assign bus.s_rdaddr      = s_addr;
  assign bus.m_rddvalid    = rvalid;
  assign bus.m_rddata      = rdata;
  assign bus.m_rdcollision = rcoll;
endmodule

// File: tb/tb_read_xbar.sv
// Directed bench for read_xbar (3 agents, 2 banks, latency 2) with a cycle-level reference model.
module tb_read_xbar;
  // Selector widened to 3 bits so that bank index 3 is encodable: bit2 = write collision.
  localparam int unsigned NA = 3;
  localparam int unsigned NB = 2;
  localparam int unsigned LAT = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  read_xbar_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NB_BANK(NB), .NB_RDAGENT(NA),
                 .SELECT_WIDTH(3)) bus ();

  read_xbar #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NB_BANK(NB), .NB_RDAGENT(NA),
              .RD_LATENCY(LAT), .WRITE_COLLISION(1), .SELECT_WIDTH(3)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  logic       en   [NA];
  logic [7:0] addr [NA];
  logic [2:0] sel  [NA];

  logic [31:0] mem [NB][256];
  logic [31:0] st1 [NB];
  logic [31:0] st2 [NB];

  bit          exp_v [NA][512];
  logic [31:0] exp_d [NA][512];
  logic [1:0]  exp_c [NA][512];

  always_ff @(posedge aclk) cyc <= cyc + 1;

  always_comb begin
    for (int a = 0; a < NA; a++) begin
      bus.m_rden[a]             = en[a];
      bus.m_rdaddr[a*8 +: 8]    = addr[a];
      bus.bank_select[a*3 +: 3] = sel[a];
    end
  end

  // Bank model: registered BRAM with two-cycle read; idle banks emit junk.
  always_ff @(posedge aclk) begin
    for (int b = 0; b < NB; b++) begin
      st1[b] <= bus.s_rden[b] ? mem[b][bus.s_rdaddr[b*8 +: 8]] : 32'hDEAD_BEEF;
      st2[b] <= st1[b];
    end
  end
  assign bus.s_rddata = {st2[1], st2[0]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit wants(input int a, input int bk);
    return en[a] && (int'(sel[a][1:0]) == bk);
  endfunction

  initial begin : model
    int last [NB];
    int win [NB];
    int cnt [NB];
    int b;
    logic [2:0]  e_ready;
    logic [1:0]  e_en;
    logic [15:0] e_addr;
    last[0] = NA - 1;
    last[1] = NA - 1;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        for (int a = 0; a < NA; a++) begin
          for (int c = cyc; c < 512; c++) begin
            exp_v[a][c] = 1'b0;
            exp_d[a][c] = '0;
            exp_c[a][c] = '0;
          end
        end
        last[0] = NA - 1;
        last[1] = NA - 1;
        check("rdready_in_reset", 64'(bus.m_rdready), 64'd0);
        check("s_rden_in_reset", 64'(bus.s_rden), 64'd0);
      end else begin
        e_en = '0;
        e_addr = '0;
        for (int bk = 0; bk < NB; bk++) begin
          win[bk] = -1;
          cnt[bk] = 0;
          for (int a = 0; a < NA; a++) if (wants(a, bk)) cnt[bk]++;
`ifdef READ_XBAR_RR_EN
          for (int k = 1; k <= NA; k++) begin
            if (win[bk] < 0 && wants((last[bk] + k) % NA, bk)) win[bk] = (last[bk] + k) % NA;
          end
`else
          for (int a = 0; a < NA; a++) if (wants(a, bk)) win[bk] = a;
`endif
          if (win[bk] >= 0) begin
            e_en[bk] = 1'b1;
            e_addr[bk*8 +: 8] = addr[win[bk]];
          end
        end
        check("s_rden", 64'(bus.s_rden), 64'(e_en));
        check("s_rdaddr", 64'(bus.s_rdaddr), 64'(e_addr));
        e_ready = '0;
        for (int a = 0; a < NA; a++) begin
          if (en[a]) begin
            b = int'(sel[a][1:0]);
            if (b >= NB) e_ready[a] = 1'b1;
            else e_ready[a] = (win[b] == a);
            if (e_ready[a]) begin
              exp_v[a][cyc+LAT] = 1'b1;
              exp_d[a][cyc+LAT] = (b >= NB) ? 32'd0 : mem[b][addr[a]];
              exp_c[a][cyc+LAT] = {(b < NB) && (cnt[b] > 1), sel[a][2]};
            end
          end
        end
        check("m_rdready", 64'(bus.m_rdready), 64'(e_ready));
        for (int bk = 0; bk < NB; bk++) if (win[bk] >= 0) last[bk] = win[bk];
      end
      for (int a = 0; a < NA; a++) begin
        check($sformatf("rddvalid[%0d]", a), 64'(bus.m_rddvalid[a]), 64'(exp_v[a][cyc]));
        check($sformatf("rddata[%0d]", a), 64'(bus.m_rddata[a*32 +: 32]), 64'(exp_d[a][cyc]));
        check($sformatf("rdcoll[%0d]", a), 64'(bus.m_rdcollision[a*2 +: 2]),
              64'(exp_c[a][cyc]));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
    #1;
  endtask

  task automatic idle();
    for (int a = 0; a < NA; a++) en[a] = 1'b0;
  endtask

  initial begin : stim
    logic [2:0] pat [4];
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < 256; a++) mem[b][a] = 32'hB000_0000 + 32'(b) * 32'h1000 + 32'(a);
    end
    mem[1][8'h10] = 32'h0000_CAFE;
    for (int a = 0; a < NA; a++) begin
      en[a] = 1'b0;
      addr[a] = '0;
      sel[a] = '0;
    end
    repeat (3) tick();
    mid();
    check("reset_rddvalid", 64'(bus.m_rddvalid), 64'd0);
    check("reset_rddata", 64'(bus.m_rddata), 64'd0);
    aresetn = 1'b1;

    // Single read: agent0, bank1, addr 0x10.
    tick();
    en[0] = 1'b1; addr[0] = 8'h10; sel[0] = 3'b001;
    mid();
    check("t1_ready", 64'(bus.m_rdready), 64'b001);
    check("t1_srden", 64'(bus.s_rden), 64'b10);
    tick();
    idle();
    tick();
    mid();
    check("t1_valid", 64'(bus.m_rddvalid), 64'b001);
    check("t1_data", 64'(bus.m_rddata[31:0]), 64'h0000_CAFE);
    check("t1_coll", 64'(bus.m_rdcollision[1:0]), 64'b00);

    // Contention on bank0 from agents 0 and 2, starting from reset pointers.
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    en[0] = 1'b1; addr[0] = 8'h20; sel[0] = 3'b000;
    en[2] = 1'b1; addr[2] = 8'h22; sel[2] = 3'b000;
`ifdef READ_XBAR_RR_EN
    pat = '{3'b001, 3'b100, 3'b001, 3'b100};
`else
    pat = '{3'b100, 3'b100, 3'b100, 3'b100};
`endif
    for (int k = 0; k < 4; k++) begin
      mid();
      check($sformatf("t2_ready%0d", k), 64'(bus.m_rdready), 64'(pat[k]));
      tick();
    end
    idle();
    mid();
`ifdef READ_XBAR_RR_EN
    check("t2_valid", 64'(bus.m_rddvalid), 64'b001);
    check("t2_coll", 64'(bus.m_rdcollision[1:0]), 64'b10);
    check("t2_data", 64'(bus.m_rddata[31:0]), 64'hB000_0020);
`else
    check("t2_valid", 64'(bus.m_rddvalid), 64'b100);
    check("t2_coll", 64'(bus.m_rdcollision[5:4]), 64'b10);
    check("t2_data", 64'(bus.m_rddata[95:64]), 64'hB000_0022);
`endif
    repeat (2) tick();

    // Write-collision flag passes through on agent1.
    en[1] = 1'b1; addr[1] = 8'h33; sel[1] = 3'b100;
    mid();
    check("t3_ready", 64'(bus.m_rdready), 64'b010);
    tick();
    idle();
    tick();
    mid();
    check("t3_valid", 64'(bus.m_rddvalid), 64'b010);
    check("t3_coll", 64'(bus.m_rdcollision[3:2]), 64'b01);
    check("t3_data", 64'(bus.m_rddata[63:32]), 64'hB000_0033);

    // Out-of-range bank index 3 on agent0.
    tick();
    en[0] = 1'b1; addr[0] = 8'h44; sel[0] = 3'b011;
    mid();
    check("t4_ready", 64'(bus.m_rdready), 64'b001);
    check("t4_srden", 64'(bus.s_rden), 64'b00);
    tick();
    idle();
    tick();
    mid();
    check("t4_valid", 64'(bus.m_rddvalid), 64'b001);
    check("t4_data", 64'(bus.m_rddata[31:0]), 64'd0);
    check("t4_coll", 64'(bus.m_rdcollision[1:0]), 64'b00);

    // Mixed traffic: bank1 contended by agents 1 and 2, then an out-of-range read with wr flag.
    tick();
    en[0] = 1'b1; addr[0] = 8'h01; sel[0] = 3'b000;
    en[1] = 1'b1; addr[1] = 8'h02; sel[1] = 3'b001;
    en[2] = 1'b1; addr[2] = 8'h03; sel[2] = 3'b101;
    repeat (3) tick();
    sel[0] = 3'b110;
    tick();
    idle();
    repeat (3) tick();

    // Reset one cycle after a grant discards the in-flight return.
    en[2] = 1'b1; addr[2] = 8'h55; sel[2] = 3'b001;
    mid();
    check("t5_ready", 64'(bus.m_rdready), 64'b100);
    tick();
    en[2] = 1'b0;
    en[0] = 1'b1; addr[0] = 8'h66; sel[0] = 3'b000;
    aresetn = 1'b0;
    mid();
    check("t5_rst_ready", 64'(bus.m_rdready), 64'b000);
    check("t5_rst_srden", 64'(bus.s_rden), 64'b00);
    check("t5_rst_valid", 64'(bus.m_rddvalid), 64'b000);
    check("t5_rst_coll", 64'(bus.m_rdcollision), 64'd0);
    tick();
    aresetn = 1'b1;
    mid();
    check("t5_post_valid", 64'(bus.m_rddvalid), 64'b000);
    check("t5_post_ready", 64'(bus.m_rdready), 64'b001);
    tick();
    idle();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
